// File: rtl/mem_agu_pkg.sv
// Shared types and constants for the burst address generation unit.
// Optional misaligned-base check is enabled by defining AGU_ALIGN_CHECK_EN.
package mem_agu_pkg;

  typedef enum logic [0:0] {
    AGU_IDLE  = 1'b0,
    AGU_ISSUE = 1'b1
  } agu_state_e;

  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefOffW     = 4;
  localparam int unsigned DefMaxBurst = 8;

  // Width of the beats-minus-one field; never narrower than one bit.
  function automatic int unsigned beat_cnt_w(input int unsigned max_burst);
    return (max_burst < 2) ? 1 : $clog2(max_burst);
  endfunction

endpackage

// File: rtl/mem_agu_addr_calc.sv
// Start address computation: halfword-aligned base plus word offset, modulo 2^ADDR_W.
// Purely combinational; no configuration macros affect this file.
module mem_agu_addr_calc
  import mem_agu_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned OFF_W  = DefOffW
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] start
);

  logic [ADDR_W-1:0] base_masked;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] off_bytes;

  assign base_masked = base & ~ADDR_W'(1);
  // Signed size cast sign-extends the word offset before scaling to bytes.
  assign off_ext     = ADDR_W'($signed(offset));
  assign off_bytes   = off_ext << 1;
  assign start       = base_masked + off_bytes;

endmodule

// File: rtl/mem_agu_burst.sv
// Multi-beat address generator: one halfword address per accepted beat, stepping by 2.
// Define AGU_ALIGN_CHECK_EN to flag odd bases as single-beat error transfers.
module mem_agu_burst
  import mem_agu_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned OFF_W     = DefOffW,
  parameter int unsigned MAX_BURST = DefMaxBurst,
  localparam int unsigned BeatW    = beat_cnt_w(MAX_BURST)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [BeatW-1:0]  req_beats_m1,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic              addr_err,
  output logic              busy
);

  agu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BeatW-1:0]  remain_q, remain_d;
  logic [ADDR_W-1:0] start_addr;

  logic issue;
  logic last_beat;
  logic beat_fire;
  logic burst_end;
  logic load;
  logic force_single;

  mem_agu_addr_calc #(
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) u_addr_calc (
    .base   (req_base),
    .offset (req_offset),
    .start  (start_addr)
  );

  assign issue     = (state_q == AGU_ISSUE);
  assign last_beat = (remain_q == '0);
  assign beat_fire = issue && addr_ready;
  assign burst_end = beat_fire && last_beat;
  // Ready on the final beat lets the next burst start with no idle bubble.
  assign req_ready = !issue || burst_end;
  assign load      = req_valid && req_ready;

`ifdef AGU_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign force_single = req_base[0];

  always_comb begin
    err_d = err_q;
    if (load) begin
      err_d = force_single;
    end else if (burst_end) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign addr_err = err_q;
`else
  assign force_single = 1'b0;
  assign addr_err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load) begin
      state_d  = AGU_ISSUE;
      addr_d   = start_addr;
      remain_d = force_single ? '0 : req_beats_m1;
    end else if (beat_fire) begin
      if (last_beat) begin
        state_d = AGU_IDLE;
      end else begin
        addr_d   = addr_q + ADDR_W'(2);
        remain_d = remain_q - BeatW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= AGU_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_valid = issue;
  assign addr       = addr_q;
  assign addr_last  = issue && last_beat;
  assign busy       = issue;

endmodule

// File: tb/tb_mem_agu_burst.sv
// Randomised and directed bench for mem_agu_burst against a queue-based beat model.
// Expectations follow AGU_ALIGN_CHECK_EN when the bench is built with it defined.
module tb_mem_agu_burst;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_base = '0;
  logic [3:0]  req_offset = '0;
  logic [2:0]  req_beats_m1 = '0;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [15:0] addr;
  logic        addr_last;
  logic        addr_err;
  logic        busy;

  typedef struct packed {
    logic [15:0] a;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    valid_cycles = 0;

  mem_agu_burst #(
    .ADDR_W    (16),
    .OFF_W     (4),
    .MAX_BURST (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_beats_m1 (req_beats_m1),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr         (addr),
    .addr_last    (addr_last),
    .addr_err     (addr_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expand an accepted request into its list of expected beats.
  function automatic void push_req(input logic [15:0] base, input logic [3:0] off,
                                   input logic [2:0] bm1);
    int          so;
    int          n;
    logic        err;
    logic [15:0] st;
    so  = $signed(off);
    st  = 16'((int'(base) & ~1) + 2 * so);
    n   = int'(bm1) + 1;
    err = 1'b0;
`ifdef AGU_ALIGN_CHECK_EN
    if (base[0]) begin
      n   = 1;
      err = 1'b1;
    end
`endif
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{a: st + 16'(2 * i), last: (i == n - 1), err: err});
    end
  endfunction

  task automatic step(input logic rv, input logic [15:0] b, input logic [3:0] o,
                      input logic [2:0] m, input logic ar);
    logic exp_valid;
    logic exp_ready;
    @(posedge clk);
    #1;
    req_valid    = rv;
    req_base     = b;
    req_offset   = o;
    req_beats_m1 = m;
    addr_ready   = ar;
    @(negedge clk);
    exp_valid = (exp_q.size() != 0);
    exp_ready = !exp_valid || (exp_q.size() == 1 && ar);
    if (addr_valid) valid_cycles++;
    check_val("addr_valid", 32'(addr_valid), 32'(exp_valid));
    check_val("busy", 32'(busy), 32'(exp_valid));
    check_val("req_ready", 32'(req_ready), 32'(exp_ready));
    if (exp_valid) begin
      check_val("addr", 32'(addr), 32'(exp_q[0].a));
      check_val("addr_last", 32'(addr_last), 32'(exp_q[0].last));
      check_val("addr_err", 32'(addr_err), 32'(exp_q[0].err));
      if (ar) void'(exp_q.pop_front());
    end
    if (rv && exp_ready) push_req(b, o, m);
  endtask

  task automatic idle_step(input logic ar);
    step(1'b0, 16'($urandom), 4'($urandom), 3'($urandom), ar);
  endtask

  initial begin
    #1;
    check_val("rst_addr_valid", 32'(addr_valid), 32'd0);
    check_val("rst_addr", 32'(addr), 32'd0);
    check_val("rst_addr_last", 32'(addr_last), 32'd0);
    check_val("rst_addr_err", 32'(addr_err), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    #21;
    rst_n = 1'b1;
    #1;
    check_val("rst_req_ready", 32'(req_ready), 32'd1);

    // Single beat at 0x1006.
    step(1'b1, 16'h1000, 4'd3, 3'd0, 1'b1);
    step(1'b0, 16'h0, 4'd0, 3'd0, 1'b1);
    check_val("single_addr", 32'(addr), 32'h1006);
    check_val("single_last", 32'(addr_last), 32'd1);
    idle_step(1'b1);

    // Negative offset from an odd base.
    step(1'b1, 16'h0021, 4'h8, 3'd3, 1'b1);
    step(1'b0, 16'h0, 4'd0, 3'd0, 1'b1);
    check_val("negoff_first", 32'(addr), 32'h0010);
    for (int i = 0; i < 4; i++) idle_step(1'b1);

    // Wrap through 0xFFFE -> 0x0000.
    step(1'b1, 16'hFFFC, 4'd0, 3'd3, 1'b1);
    for (int i = 0; i < 5; i++) idle_step(1'b1);

    // Backpressure on beat 2 of 4: seven valid cycles in total.
    step(1'b1, 16'h0100, 4'd1, 3'd3, 1'b1);
    valid_cycles = 0;
    idle_step(1'b1);
    for (int i = 0; i < 3; i++) idle_step(1'b0);
    for (int i = 0; i < 3; i++) idle_step(1'b1);
    idle_step(1'b1);
    check_val("stall_len", 32'(valid_cycles), 32'd7);

    // Back-to-back: second request on the last beat.
    step(1'b1, 16'h3000, 4'd0, 3'd1, 1'b1);
    idle_step(1'b1);
    step(1'b1, 16'h2000, 4'd0, 3'd0, 1'b1);
    idle_step(1'b1);
    check_val("b2b_addr", 32'(addr), 32'h2000);
    idle_step(1'b1);

    // Reset on beat 2 of 8.
    step(1'b1, 16'h4000, 4'd0, 3'd7, 1'b1);
    idle_step(1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("midrst_valid", 32'(addr_valid), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_last", 32'(addr_last), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h5000, 4'd2, 3'd1, 1'b1);
    step(1'b0, 16'h0, 4'd0, 3'd0, 1'b1);
    check_val("postrst_addr", 32'(addr), 32'h5004);
    idle_step(1'b1);
    idle_step(1'b1);

    // Random traffic with random backpressure and unused req fields.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 2) != 0), 16'($urandom), 4'($urandom), 3'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) idle_step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
